// File: rtl/margin_prob_calculator.sv
// margin_prob_calculator: converts a ROWS x COLS count table into
// fixed-point probabilities entry/n[row] using one shared restoring divider.
// Ports:
//   clk, rst (async, active-high)
//   margin_table_in, n_in, in_valid / in_ready : input table handshake
//   Pbc_out, div_zero_out, out_valid / out_ready : result handshake
// Optional macro PBC_ROUND_EN: one extra quotient bit, round-half-up.
module margin_prob_calculator #(
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 32,
  parameter int ROWS         = 2,
  parameter int COLS         = 3,
  parameter int FRAC_BITS    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0]     margin_table_in,
  input  logic [ROWS*DATA_WIDTH-1:0]          n_in,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [ROWS*COLS*RESULT_WIDTH-1:0]   Pbc_out,
  output logic [ROWS*COLS-1:0]                div_zero_out,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int N = ROWS * COLS;
  localparam int Q = DATA_WIDTH + FRAC_BITS;
`ifdef PBC_ROUND_EN
  localparam int ITER = Q + 1;
`else
  localparam int ITER = Q;
`endif
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW = $clog2(ITER + 1);
  localparam int WW = (RESULT_WIDTH > Q + 1) ? RESULT_WIDTH : Q + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N*DATA_WIDTH-1:0]    tab_q;
  logic [ROWS*DATA_WIDTH-1:0] n_q;
  logic [KW-1:0]              k;
  logic [RIW-1:0]             row;
  logic [CIW-1:0]             col;
  // it == 0 is the load cycle, 1..ITER are shift/subtract cycles
  logic [IW-1:0]              it;
  logic [ITER-1:0]            dvd;
  logic [DATA_WIDTH-1:0]      dvs;
  logic [DATA_WIDTH:0]        rem;
  logic [ITER-2:0]            quo;

  logic [DATA_WIDTH+1:0]      rem_sh;
  logic [DATA_WIDTH:0]        rem_nx;
  logic                       qbit;
  logic [ITER-1:0]            quo_nx;
  logic                       last_it;
  logic                       last_k;
  logic                       dz;
  logic [Q:0]                 full;
  logic [WW-1:0]              wide;
  logic                       sat;
  logic [RESULT_WIDTH-1:0]    res;
  logic [DATA_WIDTH-1:0]      entry;

  assign entry   = tab_q[k*DATA_WIDTH +: DATA_WIDTH];
  assign last_it = (it == IW'(ITER));
  assign last_k  = (k == KW'(N - 1));

  // Restoring step: one quotient bit per cycle, MSB first
  assign rem_sh = {rem, dvd[ITER-1]};
  assign qbit   = (rem_sh >= {2'b00, dvs});
  assign rem_nx = qbit ? (rem_sh[DATA_WIDTH:0] - {1'b0, dvs})
                       : rem_sh[DATA_WIDTH:0];
  assign quo_nx = {quo, qbit};
  assign dz     = (dvs == '0);

`ifdef PBC_ROUND_EN
  // Extra LSB is the half bit; adding it rounds half-up
  assign full = {1'b0, quo_nx[ITER-1:1]}
              + {{Q{1'b0}}, quo_nx[0]};
`else
  assign full = {1'b0, quo_nx};
`endif

  assign wide = WW'(full);
  assign sat  = (RESULT_WIDTH < WW) ? |(wide >> RESULT_WIDTH) : 1'b0;

  always_comb begin
    res = wide[RESULT_WIDTH-1:0];
    if (dz) begin
      res = '0;
    end else if (sat) begin
      res = '1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = DIV;
      DIV:  if (last_it && last_k) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tab_q        <= '0;
      n_q          <= '0;
      k            <= '0;
      row          <= '0;
      col          <= '0;
      it           <= '0;
      dvd          <= '0;
      dvs          <= '0;
      rem          <= '0;
      quo          <= '0;
      Pbc_out      <= '0;
      div_zero_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tab_q <= margin_table_in;
            n_q   <= n_in;
            k     <= '0;
            row   <= '0;
            col   <= '0;
            it    <= '0;
          end
        end
        DIV: begin
          if (it == '0) begin
            dvd <= ITER'(entry) << (ITER - DATA_WIDTH);
            dvs <= n_q[row*DATA_WIDTH +: DATA_WIDTH];
            rem <= '0;
            quo <= '0;
            it  <= IW'(1);
          end else begin
            dvd <= dvd << 1;
            rem <= rem_nx;
            quo <= quo_nx[ITER-2:0];
            if (last_it) begin
              Pbc_out[k*RESULT_WIDTH +: RESULT_WIDTH] <= res;
              div_zero_out[k] <= dz;
              it <= '0;
              if (last_k) begin
                k   <= '0;
                row <= '0;
                col <= '0;
              end else begin
                k <= k + KW'(1);
                if (col == CIW'(COLS - 1)) begin
                  col <= '0;
                  row <= row + RIW'(1);
                end else begin
                  col <= col + CIW'(1);
                end
              end
            end else begin
              it <= it + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_margin_prob_calculator.sv
// tb_margin_prob_calculator: directed and random tables checked against
// an arithmetic model for a 32-bit and a 24-bit result instance.
module tb_margin_prob_calculator;

  localparam int DW = 16;
  localparam int F  = 16;
  localparam int Q  = DW + F;
  localparam int NE = 6;
`ifdef PBC_ROUND_EN
  localparam int LAT = NE * (Q + 2) + 1;
`else
  localparam int LAT = NE * (Q + 1) + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [95:0]  mt;
  logic [31:0]  nn;
  logic         in_valid;
  logic         out_ready;
  logic         in_ready;
  logic         out_valid;
  logic [191:0] pbc;
  logic [5:0]   dz;
  logic         in_ready24;
  logic         out_valid24;
  logic [143:0] pbc24;
  logic [5:0]   dz24;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  margin_prob_calculator dut (
    .clk(clk), .rst(rst),
    .margin_table_in(mt), .n_in(nn),
    .in_valid(in_valid), .in_ready(in_ready),
    .Pbc_out(pbc), .div_zero_out(dz),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  margin_prob_calculator #(.RESULT_WIDTH(24)) dut24 (
    .clk(clk), .rst(rst),
    .margin_table_in(mt), .n_in(nn),
    .in_valid(in_valid), .in_ready(in_ready24),
    .Pbc_out(pbc24), .div_zero_out(dz24),
    .out_valid(out_valid24), .out_ready(out_ready)
  );

  function automatic longint model(input longint e, input longint n,
                                   input int rw);
    longint v;
    longint mx;
    if (n == 0) return 0;
`ifdef PBC_ROUND_EN
    v = ((e << (F + 1)) + n) / (2 * n);
`else
    v = (e << F) / n;
`endif
    mx = (longint'(1) << rw) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_table(input string name, input logic [95:0] t,
                           input logic [31:0] n, input int hold);
    int cyc;
    logic [191:0] snap;
    logic [5:0] zexp;
    longint e;
    longint d;
    @(negedge clk);
    mt = t;
    nn = n;
    in_valid = 1'b1;
    chk({name, "/in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    cyc = 1;
    in_valid = 1'b0;
    mt = {$urandom, $urandom, $urandom};
    nn = $urandom;
    chk({name, "/busy"}, 64'(in_ready), 64'd0);
    while (!out_valid && cyc < LAT + 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, "/latency"}, 64'(cyc), 64'(LAT));
    chk({name, "/ov24"}, 64'(out_valid24), 64'd1);
    zexp = '0;
    for (int s = 0; s < NE; s++) begin
      e = longint'(t[s*16 +: 16]);
      d = longint'(n[(s/3)*16 +: 16]);
      zexp[s] = (d == 0);
      chk($sformatf("%s/p32[%0d]", name, s),
          64'(pbc[s*32 +: 32]), 64'(model(e, d, 32)));
      chk($sformatf("%s/p24[%0d]", name, s),
          64'(pbc24[s*24 +: 24]), 64'(model(e, d, 24)));
    end
    chk({name, "/dz"}, 64'(dz), 64'(zexp));
    chk({name, "/dz24"}, 64'(dz24), 64'(zexp));
    snap = pbc;
    if (hold > 0) begin
      in_valid = 1'b1;
      mt = {$urandom, $urandom, $urandom};
      repeat (hold) @(posedge clk);
      #1;
      chk({name, "/hold_pbc"}, 64'(snap == pbc), 64'd1);
      chk({name, "/hold_dz"}, 64'(dz), 64'(zexp));
      chk({name, "/hold_ov"}, 64'(out_valid), 64'd1);
      chk({name, "/hold_ir"}, 64'(in_ready), 64'd0);
      in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "/idle_ov"}, 64'(out_valid), 64'd0);
    chk({name, "/idle_ir"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [95:0] t;
    logic [31:0] n;
    logic [15:0] n0;
    logic [15:0] n1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mt = '0;
    nn = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset/in_ready", 64'(in_ready), 64'd1);
    chk("reset/out_valid", 64'(out_valid), 64'd0);
    chk("reset/pbc", 64'(|pbc), 64'd0);
    chk("reset/dz", 64'(dz), 64'd0);

    // truncation example
    run_table("trunc",
      {16'd4, 16'd4, 16'd0, 16'd3, 16'd2, 16'd1},
      {16'd4, 16'd4}, 0);
    chk("trunc/p0_const", 64'(pbc[31:0]), 64'h4000);
    chk("trunc/p4_const", 64'(pbc[159:128]), 64'h10000);

    // zero divisor on row 1, with backpressure
    run_table("zdiv",
      {16'd7, 16'd6, 16'd5, 16'd3, 16'd2, 16'd1},
      {16'd0, 16'd4}, 50);
    chk("zdiv/dz_const", 64'(dz), 64'b111000);

    // rounding candidates
    run_table("round",
      {16'd10, 16'd9, 16'd7, 16'd0, 16'd2, 16'd1},
      {16'd11, 16'd3}, 0);
`ifdef PBC_ROUND_EN
    chk("round/p1_const", 64'(pbc[63:32]), 64'hAAAB);
`else
    chk("round/p1_const", 64'(pbc[63:32]), 64'hAAAA);
`endif

    // saturation on the 24-bit instance
    run_table("sat",
      {16'h8000, 16'd1, 16'd3, 16'd1, 16'h00FF, 16'hFFFF},
      {16'd2, 16'd1}, 2);
    chk("sat/p24_0_const", 64'(pbc24[23:0]), 64'hFFFFFF);
    chk("sat/p24_1_const", 64'(pbc24[47:24]), 64'hFF0000);

    // reset in the middle of a division
    @(negedge clk);
    mt = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4};
    nn = {16'd3, 16'd7};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (59) @(posedge clk);
    #1;
    chk("mid/busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("mid/out_valid", 64'(out_valid), 64'd0);
    chk("mid/pbc", 64'(|pbc), 64'd0);
    chk("mid/dz", 64'(dz), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid/in_ready", 64'(in_ready), 64'd1);
    run_table("fresh",
      {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4},
      {16'd3, 16'd7}, 0);

    // random tables
    for (int i = 0; i < 6; i++) begin
      t = {$urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: n0 = 16'd0;
        1: n0 = 16'($urandom_range(1, 3));
        default: n0 = 16'($urandom_range(1, 65535));
      endcase
      case ($urandom_range(0, 3))
        0: n1 = 16'd0;
        1: n1 = 16'($urandom_range(1, 3));
        default: n1 = 16'($urandom_range(1, 65535));
      endcase
      n = {n1, n0};
      run_table($sformatf("rnd%0d", i), t, n, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/margin_prob_calculator.md
# margin_prob_calculator

Parametrised, handshaked successor to the fixed 2×3 margin-probability stage. It converts a ROWS×COLS marginal count table into fixed-point probabilities, dividing every entry of row r by that row's total n[r]. A single shared iterative restoring divider replaces per-entry dividers. The block adds valid/ready flow control, divide-by-zero reporting and saturation, and sits between margin-table accumulation and the Boost statistic stage.

## Interface
- DATA_WIDTH, 16, width of each count and each row total
- RESULT_WIDTH, 32, width of each probability result
- ROWS, 2, number of table rows (and row totals)
- COLS, 3, entries per row
- FRAC_BITS, 16, fractional bits of the result
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- margin_table_in  in  ROWS*COLS*DATA_WIDTH  entry k=r*COLS+c at [k*DATA_WIDTH +: DATA_WIDTH]
- n_in  in  ROWS*DATA_WIDTH  row total r at [r*DATA_WIDTH +: DATA_WIDTH]
- in_valid  in  1  input table valid
- in_ready  out  1  block can accept a table
- Pbc_out  out  ROWS*COLS*RESULT_WIDTH  result k at [k*RESULT_WIDTH +: RESULT_WIDTH]
- div_zero_out  out  ROWS*COLS  bit k set when entry k's divisor was zero
- out_valid  out  1  results valid
- out_ready  in  1  downstream accepts results

## Operation
- Let N=ROWS*COLS and Q=DATA_WIDTH+FRAC_BITS (division iterations per entry; Q+1 with rounding, see Configuration).
- States: IDLE → DIV → DONE → IDLE.
- IDLE: in_ready=1. On in_valid: capture both input buses into internal registers, set k=0, go to DIV. Inputs are ignored after capture.
- DIV, per entry k:
  - 1 load cycle: dividend = entry k << FRAC_BITS (Q bits); divisor = n[k/COLS]; remainder cleared.
  - Then Q shift/subtract cycles, one quotient bit per cycle, MSB first. The remainder register is DATA_WIDTH+1 bits.
  - On completion, write the result into slot k and increment k.
  - After entry N-1, go to DONE.
- Result value: floor(entry·2^FRAC_BITS / n). If the Q-bit quotient exceeds 2^RESULT_WIDTH−1, saturate to all-ones. If RESULT_WIDTH ≥ Q, zero-extend.
- Zero divisor: the entry still takes the full load+Q cycles so latency stays fixed. Its result is forced to 0 and div_zero_out[k] is set.
- DONE: out_valid=1. Pbc_out and div_zero_out are held stable until out_ready. On out_valid && out_ready, go to IDLE.
- in_ready is 1 only in IDLE. Input and output transfers never overlap.

## Timing
- Reset values (async): state=IDLE, in_ready=1 as soon as rst deasserts, out_valid=0, Pbc_out=0, div_zero_out=0, k=0.
- Latency: with input accepted at cycle t, out_valid rises at cycle t+N·(Q+1)+1. Defaults (N=6, Q=32): 199 cycles.
- Throughput: one table per N·(Q+1)+2 cycles when out_ready is held high.
- out_ready low: the block stays in DONE indefinitely, outputs unchanged, in_ready=0.
- Reset mid-operation: the computation is abandoned and all outputs return to reset values on the same edge. The next table is accepted normally afterwards.
- Pbc_out slots are written progressively during DIV. They are defined only while out_valid=1.

## Configuration
- Macro: PBC_ROUND_EN.
- Defined:
  - The divider runs Q+1 iterations per entry and adds the extra (half-LSB) quotient bit to the result, giving round-half-up.
  - An increment that overflows RESULT_WIDTH saturates to all-ones.
  - Latency becomes N·(Q+2)+1.
- Undefined: truncation and the latency given above.

## Test plan
- Truncation, no macro. Row 0 = {1,2,3}, n0=4; row 1 = {0,4,4}, n1=4 → Pbc = {0x4000,0x8000,0xC000,0,0x10000,0x10000}; div_zero_out=0; out_valid exactly 199 cycles after accept.
- Zero divisor. Row 1 = {5,6,7}, n1=0 → slots 3–5 = 0, div_zero_out=6'b111000. Row 0 results correct; latency unchanged.
- Rounding, PBC_ROUND_EN. Row 0 = {1,2,0}, n0=3 → 0x5555, 0xAAAB, 0. The same stimulus without the macro gives 0x5555, 0xAAAA. With the macro, latency is 205 cycles.
- Saturation, RESULT_WIDTH=24. Entry 0xFFFF, n=1 → 0xFFFFFF. Entry 0x00FF, n=1 → 0xFF0000.
- Backpressure. Hold out_ready=0 for 50 cycles after out_valid → outputs stable, in_ready=0, new in_valid ignored. Raise out_ready → IDLE next cycle, and a back-to-back table is accepted.
- Reset mid-DIV. Assert rst at cycle 60 → out_valid=0, Pbc_out=0, in_ready=1 after release. A fresh table then produces correct results with full latency.
